// File: rtl/seq_tx_10010.sv
// seq_tx_10010: serial transmitter for bursts of the 10010 framing pattern.
// A request latches a frame count and sends that many frames, one bit per clock.
// Frames are either separated by GAP idle cycles or overlapped, where the trailing
// "10" of one frame doubles as the leading "10" of the next.
// Optional feature macro: SEQ_TX_OVERLAP_EN. Without it the overlap input is
// ignored and every frame is sent in full with GAP spacing.

module seq_tx_10010 #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             overlap,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    // Bit i holds pattern index i; sent order is 1,0,0,1,0.
    localparam logic [4:0] PATTERN = 5'b01001;
    localparam logic [2:0] LastIdx = 3'd4;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [3:0]       gap_q, gap_d;
    logic             out_d, out_valid_d, busy_d, frame_done_d, done_d;

`ifdef SEQ_TX_OVERLAP_EN
    logic ovl_q, ovl_d;
`else
    logic unused_overlap;
    assign unused_overlap = overlap;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            rem_q      <= '0;
            gap_q      <= '0;
            out        <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            done       <= 1'b0;
`ifdef SEQ_TX_OVERLAP_EN
            ovl_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            gap_q      <= gap_d;
            out        <= out_d;
            out_valid  <= out_valid_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            done       <= done_d;
`ifdef SEQ_TX_OVERLAP_EN
            ovl_q      <= ovl_d;
`endif
        end
    end

    // Next-state logic: pattern index walk, frame accounting and gap timing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
`ifdef SEQ_TX_OVERLAP_EN
        ovl_d   = ovl_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Abort in idle drops a simultaneous request.
                if (!abort && start && (count != '0)) begin
                    state_d = StSend;
                    idx_d   = '0;
                    rem_d   = count;
`ifdef SEQ_TX_OVERLAP_EN
                    ovl_d   = overlap;
`endif
                end
            end
            StSend: begin
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    rem_d   = '0;
                    gap_d   = '0;
                end else if (idx_q != LastIdx) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StIdle;
                        idx_d   = '0;
`ifdef SEQ_TX_OVERLAP_EN
                    end else if (ovl_q) begin
                        // Reuse the trailing "10" as the next frame's head.
                        idx_d = 3'd2;
`endif
                    end else if (GAP == 0) begin
                        idx_d = '0;
                    end else begin
                        state_d = StGap;
                        idx_d   = '0;
                        gap_d   = 4'(GAP - 1);
                    end
                end
            end
            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                    rem_d   = '0;
                    gap_d   = '0;
                end else if (gap_q == 4'd0) begin
                    state_d = StSend;
                    idx_d   = '0;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output next-values, decoded from the upcoming state so outputs are registered.
    always_comb begin
        out_d        = 1'b0;
        out_valid_d  = 1'b0;
        busy_d       = (state_d != StIdle);
        frame_done_d = 1'b0;
        done_d       = 1'b0;
        if (state_d == StSend) begin
            out_d        = PATTERN[idx_d];
            out_valid_d  = 1'b1;
            frame_done_d = (idx_d == LastIdx);
        end
        // Final frame completes without abort: pulse done as the burst ends.
        if ((state_q == StSend) && (idx_q == LastIdx) && !abort && (rem_q == CNT_W'(1))) begin
            done_d = 1'b1;
        end
    end

endmodule
